od_gpio_bank: RTL and testbench

Parametrised bank of open-drain GPIO channels for the ECP5 SDR board. It generalises the single tristate pin and rising-edge detector into N channels, each with:
- a registered open-drain driver
- a configurable synchroniser
- a runtime-length glitch filter
- per-channel edge-mode selection (rise/fall/both/off)
- sticky event flags with write-1-to-clear

It sits between board pins (I2C lines, buttons, external triggers) and control logic.

---
 rtl/od_gpio_pkg.sv | 26 ++
 rtl/od_gpio_chan.sv | 87 ++++++++
 rtl/od_gpio_bank.sv | 52 +++++
 tb/tb_od_gpio_bank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/od_gpio_pkg.sv
// Shared constants and helpers for the open-drain GPIO bank.
// Edge-mode encodings, default sizes and the edge-match decode.
package od_gpio_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam int DEF_FILTER_W    = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // rising = 1 when the filtered level is changing 0 -> 1
    function automatic logic edge_match(input logic [1:0] mode, input logic rising);
        logic hit;
        case (mode)
            EDGE_OFF:  hit = 1'b0;
            EDGE_RISE: hit = rising;
            EDGE_FALL: hit = ~rising;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/od_gpio_chan.sv
// One open-drain GPIO channel: driver flop, synchroniser, glitch filter,
// edge detector and sticky event flag.
module od_gpio_chan
    import od_gpio_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   FILTER_W    = DEF_FILTER_W,
    parameter logic INIT_LEVEL  = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pin_rd,
    input  logic                out_val,
    input  logic                out_oe,
    input  logic [FILTER_W-1:0] filter_len,
    input  logic [1:0]          edge_mode,
    input  logic                event_clr,
    output logic                drive_low,
    output logic                in_level,
    output logic                edge_pulse,
    output logic                event_flag
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [FILTER_W-1:0]    cnt_r;
    logic [FILTER_W-1:0]    cnt_next_s;
    logic                   drive_low_r;
    logic                   level_r;
    logic                   level_next_s;
    logic                   pulse_r;
    logic                   pulse_next_s;
    logic                   flag_r;
    logic                   flag_next_s;
    logic                   sync_out_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Driver register and input synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drive_low_r <= 1'b0;
            sync_r      <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            drive_low_r <= out_oe & ~out_val;
            sync_r      <= {sync_r[SYNC_STAGES-2:0], pin_rd};
        end
    end

    // Filter qualification, edge classification and sticky flag update.
    always_comb begin
        cnt_next_s   = cnt_r;
        level_next_s = level_r;
        pulse_next_s = 1'b0;
        if (sync_out_s == level_r) begin
            cnt_next_s = {FILTER_W{1'b0}};
        end else if (cnt_r >= filter_len) begin
            level_next_s = sync_out_s;
            cnt_next_s   = {FILTER_W{1'b0}};
            pulse_next_s = edge_match(edge_mode, sync_out_s);
        end else begin
            cnt_next_s = cnt_r + FILTER_W'(1);
        end
        // a new event beats a same-cycle clear
        flag_next_s = pulse_next_s | (flag_r & ~event_clr);
    end

    // Filter, edge and flag state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= {FILTER_W{1'b0}};
            level_r <= INIT_LEVEL;
            pulse_r <= 1'b0;
            flag_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            level_r <= level_next_s;
            pulse_r <= pulse_next_s;
            flag_r  <= flag_next_s;
        end
    end

    assign drive_low  = drive_low_r;
    assign in_level   = level_r;
    assign edge_pulse = pulse_r;
    assign event_flag = flag_r;

endmodule

// File: rtl/od_gpio_bank.sv
// Bank of independent open-drain GPIO channels sharing one filter length.
// Pins are only ever pulled low or released; external pull-ups set the high level.
module od_gpio_bank
    import od_gpio_pkg::*;
#(
    parameter int   CHANNELS    = 4,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   FILTER_W    = DEF_FILTER_W,
    parameter logic INIT_LEVEL  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    inout  wire logic [CHANNELS-1:0] pin,
    input  logic [CHANNELS-1:0]     out_val,
    input  logic [CHANNELS-1:0]     out_oe,
    input  logic [FILTER_W-1:0]     filter_len,
    input  logic [2*CHANNELS-1:0]   edge_mode,
    output logic [CHANNELS-1:0]     in_level,
    output logic [CHANNELS-1:0]     edge_pulse,
    output logic [CHANNELS-1:0]     event_flags,
    input  logic [CHANNELS-1:0]     event_clr
);

    logic [CHANNELS-1:0] drive_low_s;
    logic [CHANNELS-1:0] pin_rd_s;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        // readback is taken from the pad even while this channel drives it
        assign pin[g]      = drive_low_s[g] ? 1'b0 : 1'bz;
        assign pin_rd_s[g] = pin[g];

        od_gpio_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_W    (FILTER_W),
            .INIT_LEVEL  (INIT_LEVEL)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .pin_rd     (pin_rd_s[g]),
            .out_val    (out_val[g]),
            .out_oe     (out_oe[g]),
            .filter_len (filter_len),
            .edge_mode  (edge_mode[2*g +: 2]),
            .event_clr  (event_clr[g]),
            .drive_low  (drive_low_s[g]),
            .in_level   (in_level[g]),
            .edge_pulse (edge_pulse[g]),
            .event_flag (event_flags[g])
        );
    end

endmodule

// File: tb/tb_od_gpio_bank.sv
// Self-checking bench for od_gpio_bank: a cycle scoreboard fed by a behavioural
// model plus directed latency/count checks per scenario.
module tb_od_gpio_bank;

    localparam int CH = 4;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    tri1 [CH-1:0]  pin;
    logic [CH-1:0] out_val = '1;
    logic [CH-1:0] out_oe = '0;
    logic [CH-1:0] event_clr = '0;
    logic [CH-1:0] ext_low = '0;
    logic [FW-1:0] filter_len = '0;
    logic [2*CH-1:0] edge_mode = '0;
    logic [CH-1:0] in_level;
    logic [CH-1:0] edge_pulse;
    logic [CH-1:0] event_flags;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [CH-1:0] lvl;
        logic [CH-1:0] pls;
        logic [CH-1:0] flg;
        logic [CH-1:0] pn;
    } exp_t;
    exp_t q[$];

    logic [CH-1:0] m_s0, m_s1, m_lvl, m_pls, m_flg, m_dl;
    int            m_cnt[CH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < CH; g++) begin : g_ext
        assign pin[g] = ext_low[g] ? 1'b0 : 1'bz;
    end

    od_gpio_bank #(.CHANNELS(CH), .SYNC_STAGES(2), .FILTER_W(FW), .INIT_LEVEL(1'b1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pin         (pin),
        .out_val     (out_val),
        .out_oe      (out_oe),
        .filter_len  (filter_len),
        .edge_mode   (edge_mode),
        .in_level    (in_level),
        .edge_pulse  (edge_pulse),
        .event_flags (event_flags),
        .event_clr   (event_clr)
    );

    task automatic model_reset();
        m_s0 = '1; m_s1 = '1; m_lvl = '1;
        m_pls = '0; m_flg = '0; m_dl = '0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    endtask

    // Model one clock edge from the inputs present now and queue the expected outputs.
    task automatic model_step();
        logic [CH-1:0] pin_now, n_lvl, n_pls;
        logic [1:0] md;
        exp_t e;
        pin_now = ~(m_dl | ext_low);
        n_lvl = m_lvl;
        n_pls = '0;
        for (int i = 0; i < CH; i++) begin
            md = edge_mode[2*i +: 2];
            if (m_s1[i] == m_lvl[i]) begin
                m_cnt[i] = 0;
            end else if (m_cnt[i] >= int'(filter_len)) begin
                n_lvl[i] = m_s1[i];
                m_cnt[i] = 0;
                n_pls[i] = (md == 2'b11) || (md == 2'b01 && m_s1[i]) || (md == 2'b10 && !m_s1[i]);
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        m_s1 = m_s0;
        m_s0 = pin_now;
        m_lvl = n_lvl;
        m_pls = n_pls;
        m_flg = n_pls | (m_flg & ~event_clr);
        m_dl = out_oe & ~out_val;
        e.lvl = m_lvl; e.pls = m_pls; e.flg = m_flg; e.pn = ~(m_dl | ext_low);
        q.push_back(e);
    endtask

    // Advance one clock and compare the DUT against the oldest scoreboard entry.
    task automatic tick(input string tag);
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = q.pop_front();
        total += 4;
        if (in_level !== e.lvl) begin bad++; $display("FAIL %s in_level got=%b want=%b", tag, in_level, e.lvl); end
        if (edge_pulse !== e.pls) begin bad++; $display("FAIL %s edge_pulse got=%b want=%b", tag, edge_pulse, e.pls); end
        if (event_flags !== e.flg) begin bad++; $display("FAIL %s event_flags got=%b want=%b", tag, event_flags, e.flg); end
        if (pin !== e.pn) begin bad++; $display("FAIL %s pin got=%b want=%b", tag, pin, e.pn); end
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        total++;
        if (in_level !== 4'b1111 || edge_pulse !== 4'b0000 || event_flags !== 4'b0000) begin
            bad++; $display("FAIL reset_hold lvl/pls/flg got=%b/%b/%b want=1111/0000/0000", in_level, edge_pulse, event_flags);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int t = 0; t < 20; t++) tick("reset_idle");
        total++;
        if (in_level !== 4'b1111 || event_flags !== 4'b0000 || pin !== 4'b1111) begin
            bad++; $display("FAIL reset_idle lvl/flg/pin got=%b/%b/%b want=1111/0000/1111", in_level, event_flags, pin);
        end
    endtask

    task automatic test_drive();
        int pin_t, lvl_t, npls;
        pin_t = 0; lvl_t = 0; npls = 0;
        filter_len = 8'd0;
        edge_mode[1:0] = 2'b10;
        out_oe[0] = 1'b1; out_val[0] = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick("drive_fall");
            if (pin_t == 0 && pin[0] === 1'b0) pin_t = t;
            if (lvl_t == 0 && in_level[0] === 1'b0) lvl_t = t;
            if (edge_pulse[0] === 1'b1) npls++;
        end
        total += 3;
        if (pin_t != 1) begin bad++; $display("FAIL drive_pin_latency got=%0d want=1", pin_t); end
        if (lvl_t != 4) begin bad++; $display("FAIL drive_level_latency got=%0d want=4", lvl_t); end
        if (npls != 1) begin bad++; $display("FAIL drive_fall_pulses got=%0d want=1", npls); end
        npls = 0;
        out_oe[0] = 1'b0;
        for (int t = 0; t < 8; t++) begin tick("drive_rise_mode_fall"); if (edge_pulse[0] === 1'b1) npls++; end
        edge_mode[1:0] = 2'b01;
        out_oe[0] = 1'b1;
        for (int t = 0; t < 8; t++) begin tick("drive_fall_mode_rise"); if (edge_pulse[0] === 1'b1) npls++; end
        total++;
        if (npls != 0 || in_level[0] !== 1'b0) begin
            bad++; $display("FAIL drive_mode_mismatch pulses/lvl got=%0d/%b want=0/0", npls, in_level[0]);
        end
        out_oe[0] = 1'b0;
        for (int t = 0; t < 8; t++) tick("drive_release");
        event_clr[0] = 1'b1; tick("drive_clr");
        event_clr[0] = 1'b0; tick("drive_clr_done");
    endtask

    task automatic test_glitch();
        int npls, lvl_t;
        logic went_low;
        npls = 0; lvl_t = 0; went_low = 1'b0;
        filter_len = 8'd3;
        edge_mode[3:2] = 2'b10;
        for (int t = 1; t <= 13; t++) begin
            ext_low[1] = (t <= 3);
            tick("glitch_short");
            if (edge_pulse[1] === 1'b1) npls++;
            if (in_level[1] !== 1'b1) went_low = 1'b1;
        end
        total++;
        if (npls != 0 || went_low) begin bad++; $display("FAIL glitch_reject pulses/low got=%0d/%b want=0/0", npls, went_low); end
        ext_low[1] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick("glitch_stable");
            if (lvl_t == 0 && in_level[1] === 1'b0) lvl_t = t;
        end
        total++;
        if (lvl_t != 6) begin bad++; $display("FAIL glitch_latency got=%0d want=6", lvl_t); end
        ext_low[1] = 1'b0;
        for (int t = 0; t < 10; t++) tick("glitch_release");
    endtask

    task automatic test_bounce();
        int npls, pls_t;
        npls = 0; pls_t = 0;
        filter_len = 8'd5;
        edge_mode[5:4] = 2'b10;
        for (int t = 1; t <= 20; t++) begin
            ext_low[2] = (t != 3);
            tick("bounce");
            if (edge_pulse[2] === 1'b1) begin npls++; if (pls_t == 0) pls_t = t; end
        end
        total += 2;
        if (npls != 1) begin bad++; $display("FAIL bounce_pulses got=%0d want=1", npls); end
        if (pls_t != 11) begin bad++; $display("FAIL bounce_latency got=%0d want=11", pls_t); end
        ext_low[2] = 1'b0;
        for (int t = 0; t < 12; t++) tick("bounce_release");
    endtask

    task automatic test_sticky();
        filter_len = 8'd0;
        edge_mode[7:6] = 2'b11;
        ext_low[3] = 1'b1;
        for (int t = 0; t < 5; t++) tick("sticky_fall");
        total++;
        if (event_flags[3] !== 1'b1) begin bad++; $display("FAIL sticky_set got=%b want=1", event_flags[3]); end
        event_clr[3] = 1'b1; tick("sticky_clr1");
        event_clr[3] = 1'b0;
        total++;
        if (event_flags[3] !== 1'b0) begin bad++; $display("FAIL sticky_clear got=%b want=0", event_flags[3]); end
        ext_low[3] = 1'b0;
        tick("sticky_rise"); tick("sticky_rise");
        event_clr[3] = 1'b1; tick("sticky_collide");
        total++;
        if (edge_pulse[3] !== 1'b1 || event_flags[3] !== 1'b1) begin
            bad++; $display("FAIL sticky_set_wins pulse/flag got=%b/%b want=1/1", edge_pulse[3], event_flags[3]);
        end
        event_clr[3] = 1'b0; tick("sticky_hold");
        event_clr[3] = 1'b1; tick("sticky_clr2"); tick("sticky_clr_idle");
        event_clr[3] = 1'b0; tick("sticky_done");
        total++;
        if (event_flags[3] !== 1'b0) begin bad++; $display("FAIL sticky_late_clear got=%b want=0", event_flags[3]); end
    endtask

    task automatic test_reset_mid();
        int pls_t;
        pls_t = 0;
        filter_len = 8'd200;
        edge_mode[1:0] = 2'b10;
        ext_low[0] = 1'b1;
        for (int t = 0; t < 50; t++) tick("midreset_count");
        total++;
        if (in_level[0] !== 1'b1) begin bad++; $display("FAIL midreset_prefilter got=%b want=1", in_level[0]); end
        reset_n = 1'b0;
        model_reset();
        #2;
        total++;
        if (in_level !== 4'b1111 || edge_pulse !== 4'b0000 || event_flags !== 4'b0000) begin
            bad++; $display("FAIL midreset_async lvl/pls/flg got=%b/%b/%b want=1111/0000/0000", in_level, edge_pulse, event_flags);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int t = 1; t <= 215; t++) begin
            tick("midreset_requal");
            if (pls_t == 0 && edge_pulse[0] === 1'b1) pls_t = t;
        end
        total++;
        if (pls_t != 203) begin bad++; $display("FAIL midreset_latency got=%0d want=203", pls_t); end
        ext_low[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_drive();
        test_glitch();
        test_bounce();
        test_sticky();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
